// File: rtl/pwm_capture.sv
// PWM receive-side capture: synchronises pwm_in, measures high time and period,
// decodes the generator's 3-bit duty code and flags a line stuck high or low.
module pwm_capture #(
    parameter int CBITS = 18
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pwm_in,
    output logic           meas_valid,
    output logic [CBITS:0] high_len,
    output logic [CBITS:0] period_len,
    output logic [2:0]     duty_code,
    output logic           code_ok,
    output logic           stuck,
    output logic           stuck_level
);
    localparam logic [CBITS:0] CNT_MAX    = '1;
    localparam logic [CBITS:0] CNT_ONE    = {{CBITS{1'b0}}, 1'b1};
    localparam logic [CBITS:0] PERIOD_NOM = {1'b1, {CBITS{1'b0}}};

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic           s1_q, s2_q, s3_q;
    logic [1:0]     prime_q, prime_d;
    logic           armed_q, armed_d;
    state_t         state_q, state_d;
    logic [CBITS:0] cnt_q, cnt_d;
    logic [CBITS:0] hl_tmp_q, hl_tmp_d;
    logic           meas_valid_q, meas_valid_d;
    logic [CBITS:0] high_len_q, high_len_d;
    logic [CBITS:0] period_len_q, period_len_d;
    logic [2:0]     duty_code_q, duty_code_d;
    logic           code_ok_q, code_ok_d;
    logic           stuck_q, stuck_d;
    logic           stuck_level_q, stuck_level_d;

    logic rise, fall, cnt_max, legal;

    always_comb begin
        // The synchroniser resets to 0, so a line high at reset would look like a
        // rise; only accept rises once s2 has held a genuine low sample.
        prime_d = {prime_q[0], 1'b1};
        armed_d = armed_q | (prime_q[1] & ~s2_q);
        rise    = s2_q & ~s3_q & armed_q;
        fall    = ~s2_q & s3_q;
        cnt_max = (cnt_q == CNT_MAX);
        legal   = (cnt_q == PERIOD_NOM) && (hl_tmp_q[CBITS -: 2] == 2'b00) &&
                  hl_tmp_q[CBITS-5] && (hl_tmp_q[CBITS-6:0] == '0);

        state_d       = state_q;
        hl_tmp_d      = hl_tmp_q;
        meas_valid_d  = 1'b0;
        high_len_d    = high_len_q;
        period_len_d  = period_len_q;
        duty_code_d   = duty_code_q;
        code_ok_d     = code_ok_q;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;

        if (rise) cnt_d = CNT_ONE;
        else if (cnt_max) cnt_d = cnt_q;
        else cnt_d = cnt_q + 1'b1;

        if (rise) stuck_d = 1'b0;

        // Edges take priority over the saturation timeout.
        case (state_q)
            IDLE: begin
                if (rise) state_d = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    hl_tmp_d = cnt_q;
                    state_d  = LOW;
                end else if (cnt_max) begin
                    state_d       = IDLE;
                    stuck_d       = 1'b1;
                    stuck_level_d = s2_q;
                end
            end
            LOW: begin
                if (rise) begin
                    high_len_d   = hl_tmp_q;
                    period_len_d = cnt_q;
                    duty_code_d  = hl_tmp_q[CBITS-2 -: 3];
                    code_ok_d    = legal;
                    meas_valid_d = 1'b1;
                    state_d      = HIGH;
                end else if (cnt_max) begin
                    state_d       = IDLE;
                    stuck_d       = 1'b1;
                    stuck_level_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            prime_q       <= 2'b00;
            armed_q       <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            hl_tmp_q      <= '0;
            meas_valid_q  <= 1'b0;
            high_len_q    <= '0;
            period_len_q  <= '0;
            duty_code_q   <= 3'd0;
            code_ok_q     <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            s1_q          <= pwm_in;
            s2_q          <= s1_q;
            s3_q          <= s2_q;
            prime_q       <= prime_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hl_tmp_q      <= hl_tmp_d;
            meas_valid_q  <= meas_valid_d;
            high_len_q    <= high_len_d;
            period_len_q  <= period_len_d;
            duty_code_q   <= duty_code_d;
            code_ok_q     <= code_ok_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign meas_valid  = meas_valid_q;
    assign high_len    = high_len_q;
    assign period_len  = period_len_q;
    assign duty_code   = duty_code_q;
    assign code_ok     = code_ok_q;
    assign stuck       = stuck_q;
    assign stuck_level = stuck_level_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures a PWM waveform, the receive-side counterpart of the switch-driven PWM generator. It synchronises an asynchronous PWM input, measures high time and period in clock cycles, and decodes the 3-bit duty code carried by the generator's pulse-width encoding (high time = {0, code[2:0], 1, (CBITS-5)'b0}, period = 2^CBITS). It also flags a stuck line, either held high or held low. It sits on the input side of the board's PWM loopback/self-test path.

## Interface
- CBITS, default 18: generator counter width. Measurement counters are CBITS+1 bits wide.
- clk  input  1  single system clock; everything is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pwm_in  input  1  asynchronous PWM line.
- meas_valid  output  1  one-cycle strobe; a new high_len/period_len/duty_code/code_ok set is valid.
- high_len  output  CBITS+1  cycles pwm was high in the last complete period.
- period_len  output  CBITS+1  cycles between the last two rising edges.
- duty_code  output  3  high_len[CBITS-2:CBITS-4].
- code_ok  output  1  last measurement exactly matches a legal generator pattern.
- stuck  output  1  no edge seen for 2^(CBITS+1)-1 cycles.
- stuck_level  output  1  synchronised line level captured when stuck was set.

## Operation
- Synchroniser: s1 <= pwm_in; s2 <= s1; s3 <= s2.
- rise = s2 & ~s3; fall = ~s2 & s3.
- Counter cnt (CBITS+1 bits):
  - On rise, cnt <= 1.
  - Otherwise cnt increments and saturates at all-ones (MAX).
- FSM states: IDLE, HIGH, LOW. Reset state is IDLE.
- IDLE:
  - Wait for rise, then go to HIGH and load cnt.
  - A line already high at reset is ignored until it has fallen and risen again.
- HIGH:
  - On fall, latch hl_tmp <= cnt and go to LOW.
  - If cnt == MAX with no fall, go to IDLE and set stuck=1, stuck_level=s2 (=1).
- LOW:
  - On rise, publish: high_len <= hl_tmp; period_len <= cnt; duty_code <= hl_tmp[CBITS-2:CBITS-4]; meas_valid <= 1 for one cycle. Go to HIGH.
  - If cnt == MAX with no rise, go to IDLE and set stuck=1, stuck_level=0.
- If an edge and cnt == MAX occur in the same cycle, the edge wins and no timeout is taken.
- stuck clears on the next rise, in any state. stuck_level holds its value until stuck is set again.
- code_ok = 1 only when all of the following hold:
  - period_len == 2^CBITS;
  - hl_tmp[CBITS:CBITS-1] == 0;
  - hl_tmp[CBITS-5] == 1;
  - hl_tmp[CBITS-6:0] == 0.
- code_ok is registered with the publish. It is 0 otherwise.
- Outputs hold their last published values between strobes.
- The first measurement after reset or after a timeout needs two rising edges.
- Reset (asynchronous, mid-operation included): s1/s2/s3=0, state IDLE, cnt=0, hl_tmp=0, meas_valid=0, high_len=0, period_len=0, duty_code=0, code_ok=0, stuck=0, stuck_level=0.

## Timing
- The synchroniser plus edge detect adds 3 clk edges. If pwm_in rises before edge k, rise is registered at edge k+2 and meas_valid is high in the cycle after edge k+2.
- Measured lengths are exact in synchronised samples:
  - A line high for H sampled cycles and low for L gives high_len=H and period_len=H+L.
  - The latency is identical on both edges, so measurement error is 0 for a synchronous source and ±1 for an asynchronous one.
- Minimum measurable pulse: H=1 and L=1, giving period 2.
- meas_valid is never asserted in two consecutive cycles.
- Timeout asserts stuck in the cycle after cnt reaches MAX, i.e. 2^(CBITS+1)-1 cycles after the last edge.

## Test plan
- Generator-shaped input, CBITS=18, code=3: high 57344, low 204800, for 3 periods. The first strobe comes after the second rise. Each strobe must show high_len=57344, period_len=262144, duty_code=3, code_ok=1.
- Codes 0 and 7: high 8192, then 122880, each in a 262144 period. Required: duty_code 0 and 7, code_ok=1.
- Non-legal waveform, high 100, low 50. Required: high_len=100, period_len=150, duty_code=0, code_ok=0.
- Hold pwm_in high after one rise. After 524287 cycles: stuck=1, stuck_level=1, no meas_valid. Then drop and re-raise the line: stuck clears on the rise, and the strobe appears only after the following rise.
- Assert rst_n low in the middle of the LOW phase. All outputs go to 0 immediately. After release, the first strobe requires two fresh rises.
- 1-cycle high, 1-cycle low toggling. Required: meas_valid every 2 cycles with high_len=1 and period_len=2.
